gate_input_sequencer: RTL and testbench
=======================================

Name: gate_input_sequencer

Overview:
- Upstream stimulus stage for the two-input logic-gate block; drives its `a`/`b` inputs.
- Debounces two slide switches and two push buttons.
- Drives the gate operands either manually from the switches or automatically through the four input combinations (00, 01, 10, 11).
- Auto mode runs free at a programmable rate or single-steps on a button press, so all gate outputs can be shown on LEDs.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles before a raw input is accepted (10 ms at 100 MHz); must be >= 1.
- AUTO_PERIOD, 100000000: clock cycles per vector in free-run mode (1 s at 100 MHz); must be >= 2.
- CNT_W, 27: width of the debounce and period counters; must hold max(DEBOUNCE_CYCLES, AUTO_PERIOD-1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sw_a  in  1  raw switch, manual operand a.
- sw_b  in  1  raw switch, manual operand b.
- btn_step  in  1  raw button; single-step in hold mode.
- btn_mode  in  1  raw button; cycles the operating mode.
- a  out  1  operand a to the gate block (registered).
- b  out  1  operand b to the gate block (registered).
- mode  out  2  current mode: 00 MANUAL, 01 AUTO_RUN, 10 AUTO_HOLD; 11 never driven.
- new_vec  out  1  one-cycle pulse in the cycle `{a,b}` takes a new value.

Behaviour:
- Reset (rst=1 at clk edge):
  - a=0, b=0, mode=00, new_vec=0.
  - All debounced values 0; all counters 0.
  - Reset takes priority over every other event, including mid-count and mid-step.
- Debounce, one instance per raw input:
  - Counter increments while raw != debounced value.
  - Counter clears to 0 on any cycle where raw == debounced value.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced value takes the raw value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never propagates.
  - A button held through reset produces a rising edge DEBOUNCE_CYCLES cycles after reset deasserts.
- Edge detect:
  - step_p and mode_p are one-cycle pulses on 0->1 of the debounced btn_step and btn_mode.
  - Release edges are ignored.
- State machine, state equals `mode`:
  - MANUAL:
    - vec <= {db_sw_a, db_sw_b} every cycle.
    - On mode_p: go to AUTO_RUN, vec <= 00, timer <= 0.
  - AUTO_RUN:
    - Timer counts 0..AUTO_PERIOD-1.
    - At terminal count: timer <= 0 and vec <= vec+1 mod 4 (11 wraps to 00).
    - On mode_p: go to AUTO_HOLD, timer frozen, vec unchanged.
  - AUTO_HOLD:
    - Timer frozen.
    - On step_p: vec <= vec+1 mod 4.
    - On mode_p: go to MANUAL; vec loads the switches the next cycle.
  - step_p is ignored in MANUAL and AUTO_RUN.
- Simultaneous events:
  - mode_p and step_p together: mode_p wins; the step is discarded.
  - mode_p together with AUTO_RUN terminal count: mode_p wins; no advance.
- Outputs:
  - `{a,b}` = vec, with a as MSB, registered.
  - Latency is one cycle from the triggering event (debounced change, pulse, or terminal count) to the new `{a,b}`.
  - new_vec=1 exactly in the cycle the registered `{a,b}` differs from its previous value. This includes manual switch changes and mode transitions that change vec.
  - new_vec=0 when a mode transition leaves vec unchanged.

Optional Feature:
- INPUT_SYNC_EN:
  - When defined: each of the four raw inputs passes through a two-flop synchronizer (reset to 0) before its debouncer. Every input-to-output latency grows by 2 cycles.
  - When undefined: raw inputs feed the debouncers directly (inputs already synchronous in the lab setup).
- All other behaviour is identical in both builds.

Test Plan (DEBOUNCE_CYCLES=4, AUTO_PERIOD=8, INPUT_SYNC_EN undefined unless stated):
- Reset then idle 20 cycles -> a=0, b=0, mode=00, new_vec never 1.
- In MANUAL: sw_a=1 pulsed high for 3 cycles -> no change. sw_a=1 held -> `{a,b}`=10 after 4+1 cycles, new_vec high for exactly 1 cycle.
- Press btn_mode once (held 10 cycles) -> mode=01, `{a,b}`=00. Then `{a,b}` steps 01, 10, 11, 00 every 8 cycles, with a new_vec pulse at each step.
- Second btn_mode press -> mode=10, `{a,b}` frozen for 50 cycles. Three btn_step presses -> `{a,b}` advances 3 values mod 4, one new_vec per press.
- btn_mode and btn_step debounced rising edges in the same cycle while in AUTO_HOLD -> mode=00, no vec advance. `{a,b}` equals the switches one cycle later.
- Assert rst mid AUTO_RUN with `{a,b}`=10 and timer at 5 -> next edge `{a,b}`=00, mode=00. Repeat with INPUT_SYNC_EN defined -> the manual switch latency is 4+1+2 cycles.

Source files
------------

// File: rtl/gate_input_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : gate_input_sequencer
//  Description : Debounces two slide switches and two push buttons and drives
//                the a/b operands of a two-input gate block, either from the
//                switches (MANUAL) or by walking 00,01,10,11 in free-run
//                (AUTO_RUN) or single-step (AUTO_HOLD) mode.
//                Optional macro INPUT_SYNC_EN inserts a two-flop synchronizer
//                in front of each debouncer (+2 cycles of input latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_input_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int AUTO_PERIOD     = 100000000,
  parameter int CNT_W           = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_a,
  input  logic       sw_b,
  input  logic       btn_step,
  input  logic       btn_mode,
  output logic       a,
  output logic       b,
  output logic [1:0] mode,
  output logic       new_vec
);

  localparam logic [1:0] S_MANUAL    = 2'b00;
  localparam logic [1:0] S_AUTO_RUN  = 2'b01;
  localparam logic [1:0] S_AUTO_HOLD = 2'b10;

  localparam logic [CNT_W-1:0] c_DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_TMR_LAST = CNT_W'(AUTO_PERIOD - 1);

  // Bit order of the packed input bundle: [3]=sw_a [2]=sw_b [1]=btn_step [0]=btn_mode
  logic [3:0] w_raw;
  logic [3:0] w_db_in;
  logic [3:0] w_db;
  assign w_raw = {sw_a, sw_b, btn_step, btn_mode};

`ifdef INPUT_SYNC_EN
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;

  // Two-flop synchronizer on every raw input before debouncing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_db_in = r_sync2;
`else
  assign w_db_in = w_raw;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_db
      logic             r_bit;
      logic [CNT_W-1:0] r_cnt;

      // Accept the input only after it has differed from the held value for
      // DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count
      always_ff @(posedge clk) begin
        if (rst) begin
          r_bit <= 1'b0;
          r_cnt <= '0;
        end else if (w_db_in[gi] == r_bit) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DB_LAST) begin
          r_bit <= w_db_in[gi];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_db[gi] = r_bit;
    end
  endgenerate

  logic [3:0] r_db_d;
  logic       w_step_p;
  logic       w_mode_p;

  // Previous debounced values for rising-edge detection of the buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_d <= '0;
    end else begin
      r_db_d <= w_db;
    end
  end

  assign w_step_p = w_db[1] & ~r_db_d[1];
  assign w_mode_p = w_db[0] & ~r_db_d[0];

  logic [1:0]       r_mode;
  logic [1:0]       r_vec;
  logic [CNT_W-1:0] r_tmr;
  logic             r_new_vec;
  logic [1:0]       w_mode_nx;
  logic [1:0]       w_vec_nx;
  logic [CNT_W-1:0] w_tmr_nx;

  // Next-state logic; a mode press always takes precedence over a step or a
  // free-run terminal count landing in the same cycle
  always_comb begin
    w_mode_nx = r_mode;
    w_vec_nx  = r_vec;
    w_tmr_nx  = r_tmr;
    case (r_mode)
      S_MANUAL: begin
        if (w_mode_p) begin
          w_mode_nx = S_AUTO_RUN;
          w_vec_nx  = 2'b00;
          w_tmr_nx  = '0;
        end else begin
          w_vec_nx = {w_db[3], w_db[2]};
        end
      end
      S_AUTO_RUN: begin
        if (w_mode_p) begin
          w_mode_nx = S_AUTO_HOLD;
        end else if (r_tmr == c_TMR_LAST) begin
          w_tmr_nx = '0;
          w_vec_nx = r_vec + 2'd1;
        end else begin
          w_tmr_nx = r_tmr + 1'b1;
        end
      end
      S_AUTO_HOLD: begin
        if (w_mode_p) begin
          w_mode_nx = S_MANUAL;
        end else if (w_step_p) begin
          w_vec_nx = r_vec + 2'd1;
        end
      end
      default: begin
        w_mode_nx = S_MANUAL;
        w_vec_nx  = 2'b00;
        w_tmr_nx  = '0;
      end
    endcase
  end

  // State, operand and change-flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode    <= S_MANUAL;
      r_vec     <= 2'b00;
      r_tmr     <= '0;
      r_new_vec <= 1'b0;
    end else begin
      r_mode    <= w_mode_nx;
      r_vec     <= w_vec_nx;
      r_tmr     <= w_tmr_nx;
      r_new_vec <= (w_vec_nx != r_vec);
    end
  end

  assign a       = r_vec[1];
  assign b       = r_vec[0];
  assign mode    = r_mode;
  assign new_vec = r_new_vec;

endmodule
`default_nettype wire

// File: tb/tb_gate_input_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gate_input_sequencer
//  Description : Self-checking bench for gate_input_sequencer with
//                DEBOUNCE_CYCLES=4, AUTO_PERIOD=8. Directed table, corner
//                sequences and random stimulus against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_input_sequencer;

  localparam int DB  = 4;
  localparam int PER = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_a = 1'b0, sw_b = 1'b0, btn_step = 1'b0, btn_mode = 1'b0;
  logic       a, b, new_vec;
  logic [1:0] mode;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  gate_input_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .AUTO_PERIOD    (PER),
    .CNT_W          (27)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw_a    (sw_a),
    .sw_b    (sw_b),
    .btn_step(btn_step),
    .btn_mode(btn_mode),
    .a       (a),
    .b       (b),
    .mode    (mode),
    .new_vec (new_vec)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // Inputs indexed 0=sw_a 1=sw_b 2=btn_step 3=btn_mode
  int m_run[4];
  bit m_db[4];
  bit m_dbq[4];
  bit m_s1[4];
  bit m_s2[4];
  int m_mode = 0;
  int m_vec  = 0;
  int m_tmr  = 0;
  bit m_nv   = 0;

  always @(posedge clk) begin
    bit raw[4];
    bit din[4];
    bit stepp, modep;
    int nvec, nmode, ntmr;
    raw = '{sw_a, sw_b, btn_step, btn_mode};
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_run[i] = 0; m_db[i] = 0; m_dbq[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
      end
      m_mode = 0; m_vec = 0; m_tmr = 0; m_nv = 0;
    end else begin
`ifdef INPUT_SYNC_EN
      din  = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
`else
      din = raw;
`endif
      stepp = m_db[2] && !m_dbq[2];
      modep = m_db[3] && !m_dbq[3];
      nvec = m_vec; nmode = m_mode; ntmr = m_tmr;
      case (m_mode)
        0: if (modep) begin nmode = 1; nvec = 0; ntmr = 0; end
           else nvec = 2 * int'(m_db[0]) + int'(m_db[1]);
        1: if (modep) nmode = 2;
           else if (m_tmr == PER - 1) begin ntmr = 0; nvec = (m_vec + 1) % 4; end
           else ntmr = m_tmr + 1;
        default: if (modep) nmode = 0;
           else if (stepp) nvec = (m_vec + 1) % 4;
      endcase
      m_nv = (nvec != m_vec);
      for (int i = 0; i < 4; i++) begin
        m_dbq[i] = m_db[i];
        if (din[i] == m_db[i]) m_run[i] = 0;
        else begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DB) begin m_db[i] = din[i]; m_run[i] = 0; end
        end
      end
      m_vec = nvec; m_mode = nmode; m_tmr = ntmr;
    end
  end

  // Cycle-by-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if ({a, b} != 2'(m_vec) || mode != 2'(m_mode) || new_vec != m_nv) begin
        n_err++;
        if (n_err < 20)
          $display("FAIL model t=%0t: ab=%b mode=%b nv=%b, required ab=%b mode=%b nv=%b",
                   $time, {a, b}, mode, new_vec, 2'(m_vec), 2'(m_mode), m_nv);
      end
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    bit       sa;
    bit       sb;
    bit       st;
    bit       md;
    int       cyc;
    bit [1:0] ab;
    bit [1:0] md_exp;
  } row_t;

  row_t tbl[17];

  task automatic check_out(input int id, input bit [1:0] ab_exp, input bit [1:0] md_exp);
    n_chk++;
    if ({a, b} != ab_exp || mode != md_exp) begin
      n_err++;
      $display("FAIL row%0d: ab=%b mode=%b, required ab=%b mode=%b",
               id, {a, b}, mode, ab_exp, md_exp);
    end
  endtask

  initial begin
    bit hit;
    tbl[0]  = '{0, 0, 0, 0, 20, 2'b00, 2'b00};  // idle after reset
    tbl[1]  = '{1, 0, 0, 0,  3, 2'b00, 2'b00};  // 3-cycle glitch
    tbl[2]  = '{0, 0, 0, 0, 10, 2'b00, 2'b00};
    tbl[3]  = '{1, 0, 0, 0, 10, 2'b10, 2'b00};  // switch a accepted
    tbl[4]  = '{1, 0, 0, 1, 10, 2'b00, 2'b01};  // enter AUTO_RUN
    tbl[5]  = '{1, 0, 0, 0, 10, 2'b01, 2'b01};
    tbl[6]  = '{1, 0, 0, 0, 16, 2'b11, 2'b01};
    tbl[7]  = '{1, 0, 0, 1, 10, 2'b00, 2'b10};  // wrap to 00, then AUTO_HOLD
    tbl[8]  = '{1, 0, 0, 0, 50, 2'b00, 2'b10};  // frozen
    tbl[9]  = '{1, 0, 1, 0, 10, 2'b01, 2'b10};  // step 1
    tbl[10] = '{1, 0, 0, 0, 10, 2'b01, 2'b10};
    tbl[11] = '{1, 0, 1, 0, 10, 2'b10, 2'b10};  // step 2
    tbl[12] = '{1, 0, 0, 0, 10, 2'b10, 2'b10};
    tbl[13] = '{1, 0, 1, 0, 10, 2'b11, 2'b10};  // step 3
    tbl[14] = '{1, 0, 0, 0, 10, 2'b11, 2'b10};
    tbl[15] = '{0, 1, 1, 1, 10, 2'b01, 2'b00};  // mode+step together: mode wins
    tbl[16] = '{0, 0, 0, 0, 10, 2'b00, 2'b00};

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check_out(100, 2'b00, 2'b00);
    rst = 1'b0;

    for (int r = 0; r < 17; r++) begin
      sw_a = tbl[r].sa; sw_b = tbl[r].sb; btn_step = tbl[r].st; btn_mode = tbl[r].md;
      repeat (tbl[r].cyc) @(posedge clk);
      @(negedge clk);
      check_out(r, tbl[r].ab, tbl[r].md_exp);
    end

    // Reset in AUTO_RUN with {a,b}=10 and timer at 5
    sw_a = 1'b1; btn_mode = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 10) btn_mode = 1'b0;
      if (m_mode == 1 && m_vec == 2 && m_tmr == 5) hit = 1'b1;
    end
    n_chk++;
    if (!hit) begin
      n_err++;
      $display("FAIL reach_run10: target state not reached, required mode=01 ab=10 tmr=5");
    end
    check_out(101, 2'b10, 2'b01);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_out(102, 2'b00, 2'b00);
    n_chk++;
    if (new_vec !== 1'b0) begin
      n_err++;
      $display("FAIL rst_newvec: new_vec=%b, required 0", new_vec);
    end
    rst = 1'b0;

    // Manual latency check: DB+1 cycles (plus 2 with the synchronizer)
    sw_a = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    sw_a = 1'b1;
`ifdef INPUT_SYNC_EN
    repeat (DB + 2) @(posedge clk);
`else
    repeat (DB) @(posedge clk);
`endif
    @(negedge clk);
    check_out(103, 2'b00, 2'b00);
    @(posedge clk);
    @(negedge clk);
    check_out(104, 2'b10, 2'b00);

    // Random stimulus with hold times around the debounce window
    begin
      int hold[4];
      for (int i = 0; i < 4; i++) hold[i] = 0;
      for (int c = 0; c < 4000; c++) begin
        for (int i = 0; i < 4; i++) begin
          if (hold[i] == 0) begin
            hold[i] = $urandom_range(1, 12);
            case (i)
              0: sw_a     = $urandom_range(0, 1);
              1: sw_b     = $urandom_range(0, 1);
              2: btn_step = $urandom_range(0, 1);
              default: btn_mode = $urandom_range(0, 1);
            endcase
          end else begin
            hold[i]--;
          end
        end
        rst = ($urandom_range(0, 399) == 0);
        @(posedge clk);
        @(negedge clk);
      end
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
